ysyx_22050058_wb_arbiter: RTL

- Shares the single regfile write port between two writeback sources.
  - Source A: the main in-order pipeline. It has fixed high priority.
  - Source B: a long-latency unit (MDU/LSU). Starvation guard guarantees it progress.
- Keeps a per-register scoreboard of pending source-B destinations.
- Raises stall_o to the decode stage for any read of a pending register that is not being written this cycle.
- Sits between EXU/LSU/MDU writeback and the regfile write port. Its outputs drive we_i/waddr_i/wdata_i directly.

---
 rtl/ysyx_22050058_wb_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ysyx_22050058_wb_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_22050058_wb_arbiter
//
// Shares the single regfile write port between two writeback sources.
//   Source A: the in-order pipeline, fixed high priority.
//   Source B: a long-latency unit (MDU/LSU). A starvation counter forces a
//             B grant after STARVE_MAX consecutive lost cycles.
// It also keeps a per-register scoreboard of pending B destinations and
// stalls decode on any read of a pending register that is not being
// written (and therefore forwarded) in the same cycle.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   a_valid_i/a_ready_o          source A handshake
//   a_waddr_i/a_wdata_i          source A destination and data
//   b_valid_i/b_ready_o          source B handshake
//   b_waddr_i/b_wdata_i          source B destination and data
//   we_o/waddr_o/wdata_o         regfile write port
//   sb_set_i/sb_set_addr_i       a B-bound op with a destination issues
//   re1_i/raddr1_i, re2_i/raddr2_i decode read ports
//   stall_o                      decode must hold
//   busy_o                       scoreboard, bit i = register i pending
// ---------------------------------------------------------------------------
module ysyx_22050058_wb_arbiter #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 5,
  parameter int NUM_REGS   = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid_i,
  output logic                a_ready_o,
  input  logic [ADDR_W-1:0]   a_waddr_i,
  input  logic [DATA_W-1:0]   a_wdata_i,
  input  logic                b_valid_i,
  output logic                b_ready_o,
  input  logic [ADDR_W-1:0]   b_waddr_i,
  input  logic [DATA_W-1:0]   b_wdata_i,
  output logic                we_o,
  output logic [ADDR_W-1:0]   waddr_o,
  output logic [DATA_W-1:0]   wdata_o,
  input  logic                sb_set_i,
  input  logic [ADDR_W-1:0]   sb_set_addr_i,
  input  logic                re1_i,
  input  logic [ADDR_W-1:0]   raddr1_i,
  input  logic                re2_i,
  input  logic [ADDR_W-1:0]   raddr2_i,
  output logic                stall_o,
  output logic [NUM_REGS-1:0] busy_o
);

  logic [3:0]          starve_cnt_r;
  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_nxt_s;
  logic                b_pri_s;
  logic                grant_a_s;
  logic                grant_b_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic                we_s;
  logic                set_en_s;
  logic                clr_en_s;
  logic                rd1_busy_s;
  logic                rd2_busy_s;
  logic                hit1_s;
  logic                hit2_s;

  // Grants are suppressed during reset so no handshake completes then.
  assign b_pri_s   = (starve_cnt_r == 4'(STARVE_MAX));
  assign grant_b_s = ~rst & b_valid_i & (~a_valid_i | b_pri_s);
  assign grant_a_s = ~rst & a_valid_i & ~grant_b_s;

  // Write-port mux: granted source drives address/data, zero when idle.
  always_comb begin
    sel_addr_s = '0;
    sel_data_s = '0;
    if (grant_a_s) begin
      sel_addr_s = a_waddr_i;
      sel_data_s = a_wdata_i;
    end else if (grant_b_s) begin
      sel_addr_s = b_waddr_i;
      sel_data_s = b_wdata_i;
    end else begin
      sel_addr_s = '0;
      sel_data_s = '0;
    end
  end

  // x0 writes still complete the handshake but never reach the regfile.
  assign we_s = (grant_a_s | grant_b_s) & (sel_addr_s != {ADDR_W{1'b0}});

  assign a_ready_o = grant_a_s;
  assign b_ready_o = grant_b_s;
  assign we_o      = we_s;
  assign waddr_o   = sel_addr_s;
  assign wdata_o   = sel_data_s;

  // Starvation counter: counts consecutive cycles B waits, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= 4'd0;
    end else if (b_valid_i && !grant_b_s) begin
      if (starve_cnt_r == 4'(STARVE_MAX)) begin
        starve_cnt_r <= starve_cnt_r;
      end else begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end
    end else begin
      starve_cnt_r <= 4'd0;
    end
  end

  assign set_en_s = sb_set_i  & (sb_set_addr_i != {ADDR_W{1'b0}});
  assign clr_en_s = grant_b_s & (b_waddr_i     != {ADDR_W{1'b0}});

  // Scoreboard next state; a set beats a clear on the same register.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (set_en_s && (sb_set_addr_i == ADDR_W'(i))) begin
        busy_nxt_s[i] = 1'b1;
      end else if (clr_en_s && (b_waddr_i == ADDR_W'(i))) begin
        busy_nxt_s[i] = 1'b0;
      end else begin
        busy_nxt_s[i] = busy_r[i];
      end
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign busy_o = busy_r;

  // Pending-bit lookup for both decode read ports.
  always_comb begin
    rd1_busy_s = 1'b0;
    rd2_busy_s = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd1_busy_s = rd1_busy_s | (busy_r[i] & (raddr1_i == ADDR_W'(i)));
      rd2_busy_s = rd2_busy_s | (busy_r[i] & (raddr2_i == ADDR_W'(i)));
    end
  end

  // A read of the register B is writing right now is served by the
  // regfile's write-through forwarding, so it does not stall.
  assign hit1_s  = re1_i & rd1_busy_s & ~(we_s & grant_b_s & (sel_addr_s == raddr1_i));
  assign hit2_s  = re2_i & rd2_busy_s & ~(we_s & grant_b_s & (sel_addr_s == raddr2_i));
  assign stall_o = ~rst & (hit1_s | hit2_s);

endmodule
